// File: rtl/uarc_pkg.sv
// Shared types and constants for the UARC interrupt arbiter.
package uarc_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_PENDING,
    ARB_ACK
  } arb_state_t;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

endpackage

// File: rtl/uarc_rr_priority_encoder.sv
// Rotating priority encoder: returns the first set line at or after ptr_i,
// wrapping from LINES-1 back to 0. With ptr_i = 0 this is plain lowest-index-wins.
module rr_priority_encoder #(
  parameter int unsigned LINES     = 4,
  parameter int unsigned OUT_WIDTH = 2
) (
  input  logic [LINES-1:0]     lines_i,
  input  logic [OUT_WIDTH-1:0] ptr_i,
  output logic [OUT_WIDTH-1:0] idx_o,
  output logic                 on_o
);

  // Scan offsets 0..LINES-1 from the pointer and keep the first hit.
  always_comb begin
    int unsigned      pos;
    logic [LINES-1:0] shifted;
    logic             found;
    pos     = 0;
    shifted = '0;
    found   = 1'b0;
    idx_o   = '0;
    for (int unsigned k = 0; k < LINES; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= LINES) pos = pos - LINES;
      shifted = lines_i >> pos;
      if (!found && shifted[0]) begin
        found = 1'b1;
        idx_o = OUT_WIDTH'(pos);
      end
    end
    on_o = found;
  end

endmodule

// File: rtl/uarc_interrupt_arbiter.sv
// Registered N-bus UARC send/interrupt arbiter. Picks one eligible receiver send,
// presents bus/handler address/data to the core and acks the sender on take.
// Optional PENDING watchdog enabled by defining UARC_IRQ_TIMEOUT_EN.
module uarc_interrupt_arbiter
  import uarc_pkg::*;
#(
  parameter int unsigned WORD_MAG           = 5,
  parameter int unsigned TOTAL_BUSES        = 4,
  parameter int unsigned PROGRAM_ADDR_WIDTH = 8,
  parameter int unsigned ARB_MODE           = ARB_FIXED,
  parameter int unsigned TIMEOUT_CYCLES     = 64
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [TOTAL_BUSES-1:0]                    receiver_sends,
  input  logic [TOTAL_BUSES*(1<<WORD_MAG)-1:0]      receiver_datas,
  input  logic [TOTAL_BUSES-1:0]                    interrupt_enables,
  input  logic [TOTAL_BUSES-1:0]                    bus_selections,
  input  logic                                      core_wait,
  input  logic                                      interrupt_active,
  input  logic                                      irq_take,
  input  logic                                      cfg_we,
  input  logic [(1<<WORD_MAG)-1:0]                  cfg_bus,
  input  logic [PROGRAM_ADDR_WIDTH-1:0]             cfg_addr,
  output logic                                      irq_valid,
  output logic [(1<<WORD_MAG)-1:0]                  irq_bus,
  output logic [PROGRAM_ADDR_WIDTH-1:0]             irq_address,
  output logic [(1<<WORD_MAG)-1:0]                  irq_data,
  output logic [TOTAL_BUSES-1:0]                    receiver_send_acks,
  output logic                                      irq_timeout
);

  localparam int unsigned W    = 1 << WORD_MAG;
  localparam int unsigned N    = TOTAL_BUSES;
  localparam int unsigned PAW  = PROGRAM_ADDR_WIDTH;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  arb_state_t          state_q, state_d;
  logic [IdxW-1:0]     bus_q, bus_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [N-1:0]        block_q, block_d;
  logic [N-1:0]        acks_q, acks_d;
  logic [PAW-1:0]      table_q [N];
  logic [PAW-1:0]      table_d [N];

  logic [N-1:0]        mask;
  logic [N-1:0]        eligible;
  logic [N-1:0]        cur_oh;
  logic                cur_send;
  logic                cur_mask;
  logic [W-1:0]        cur_data;
  logic [PAW-1:0]      cur_addr;
  logic [IdxW-1:0]     start_ptr;
  logic [IdxW-1:0]     win_idx;
  logic                win_on;
  logic [IdxW-1:0]     ptr_next;

`ifdef UARC_IRQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
`endif

  // Active mask: WAIT uses bus_selections; a running handler blocks normal grants.
  always_comb begin
    mask = '0;
    if (core_wait) begin
      mask = bus_selections;
    end else if (!interrupt_active) begin
      mask = interrupt_enables;
    end
    eligible = receiver_sends & ~block_q & mask;
  end

  // Views of the currently latched bus: send, mask bit, data and handler address.
  always_comb begin
    cur_oh   = N'(1) << bus_q;
    cur_send = |(receiver_sends & cur_oh);
    cur_mask = |(mask & cur_oh);
    cur_data = '0;
    cur_addr = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cur_oh[i]) begin
        cur_data = receiver_datas[i*W +: W];
        cur_addr = table_q[i];
      end
    end
  end

  assign start_ptr = (ARB_MODE == ARB_RR) ? ptr_q : '0;
  assign ptr_next  = (bus_q == IdxW'(N - 1)) ? '0 : bus_q + IdxW'(1);

  rr_priority_encoder #(
    .LINES     (N),
    .OUT_WIDTH (IdxW)
  ) u_rr_priority_encoder (
    .lines_i (eligible),
    .ptr_i   (start_ptr),
    .idx_o   (win_idx),
    .on_o    (win_on)
  );

  // Handler table next state; indices at or above N never match and are dropped.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      table_d[i] = table_q[i];
      if (cfg_we && (cfg_bus == W'(i))) begin
        table_d[i] = cfg_addr;
      end
    end
  end

  // Arbiter FSM next state: grant, present, ack, and block bookkeeping.
  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    ptr_d   = ptr_q;
    acks_d  = '0;
    // A block bit survives only while its send stays high.
    block_d = block_q & receiver_sends;
`ifdef UARC_IRQ_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (win_on) begin
          state_d = ARB_PENDING;
          bus_d   = win_idx;
`ifdef UARC_IRQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_PENDING: begin
        // Take has priority over a same-cycle withdrawal or mask change.
        if (irq_take) begin
          state_d = ARB_ACK;
          acks_d  = cur_oh;
        end else if (!cur_send || !cur_mask) begin
          state_d = ARB_IDLE;
`ifdef UARC_IRQ_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ARB_IDLE;
          block_d   = block_d | cur_oh;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      ARB_ACK: begin
        // The held send must drop before it can win again.
        block_d = block_d | cur_oh;
        ptr_d   = ptr_next;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // FSM and arbitration state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ARB_IDLE;
      bus_q     <= '0;
      ptr_q     <= '0;
      block_q   <= '0;
      acks_q    <= '0;
`ifdef UARC_IRQ_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bus_q     <= bus_d;
      ptr_q     <= ptr_d;
      block_q   <= block_d;
      acks_q    <= acks_d;
`ifdef UARC_IRQ_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Handler address table.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) table_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) table_q[i] <= table_d[i];
    end
  end

  assign irq_valid          = (state_q == ARB_PENDING);
  assign irq_bus            = W'(bus_q);
  assign irq_address        = irq_valid ? cur_addr : '0;
  assign irq_data           = irq_valid ? cur_data : '0;
  assign receiver_send_acks = acks_q;
`ifdef UARC_IRQ_TIMEOUT_EN
  assign irq_timeout        = timeout_q;
`else
  assign irq_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_uarc_interrupt_arbiter.sv
// Bench for uarc_interrupt_arbiter: a fixed-priority and a round-robin instance
// share one set of inputs and are checked every cycle against a behavioural model.
module tb_uarc_interrupt_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int PAW = 8;
  localparam int TMO = 8;
`ifdef UARC_IRQ_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     sends = '0, en = '0, bsel = '0;
  logic [N*W-1:0]   datas = '0;
  logic             cwait = 1'b0, iact = 1'b0, take = 1'b0, cfg_we = 1'b0;
  logic [W-1:0]     cfg_bus = '0;
  logic [PAW-1:0]   cfg_addr = '0;

  logic [1:0]          o_valid, o_tout;
  logic [1:0][W-1:0]   o_bus, o_data;
  logic [1:0][PAW-1:0] o_addr;
  logic [1:0][N-1:0]   o_acks;

  int n_checks = 0;
  int n_err    = 0;
  string iname [2] = '{"fix", "rr"};

  // Model state, index 0 = fixed instance, 1 = round-robin instance.
  bit             m_pres [2];
  bit             m_ack  [2];
  int             m_bus  [2];
  int             m_ptr  [2];
  int             m_cnt  [2];
  bit             m_tout [2];
  bit             m_blk  [2][N];
  logic [PAW-1:0] m_tab  [N];

  uarc_interrupt_arbiter #(
    .WORD_MAG(5), .TOTAL_BUSES(N), .PROGRAM_ADDR_WIDTH(PAW), .ARB_MODE(0), .TIMEOUT_CYCLES(TMO)
  ) u_fixed (
    .clk(clk), .reset(reset), .receiver_sends(sends), .receiver_datas(datas),
    .interrupt_enables(en), .bus_selections(bsel), .core_wait(cwait),
    .interrupt_active(iact), .irq_take(take), .cfg_we(cfg_we), .cfg_bus(cfg_bus),
    .cfg_addr(cfg_addr), .irq_valid(o_valid[0]), .irq_bus(o_bus[0]),
    .irq_address(o_addr[0]), .irq_data(o_data[0]), .receiver_send_acks(o_acks[0]),
    .irq_timeout(o_tout[0])
  );

  uarc_interrupt_arbiter #(
    .WORD_MAG(5), .TOTAL_BUSES(N), .PROGRAM_ADDR_WIDTH(PAW), .ARB_MODE(1), .TIMEOUT_CYCLES(TMO)
  ) u_rr (
    .clk(clk), .reset(reset), .receiver_sends(sends), .receiver_datas(datas),
    .interrupt_enables(en), .bus_selections(bsel), .core_wait(cwait),
    .interrupt_active(iact), .irq_take(take), .cfg_we(cfg_we), .cfg_bus(cfg_bus),
    .cfg_addr(cfg_addr), .irq_valid(o_valid[1]), .irq_bus(o_bus[1]),
    .irq_address(o_addr[1]), .irq_data(o_data[1]), .receiver_send_acks(o_acks[1]),
    .irq_timeout(o_tout[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] cur_mask();
    if (cwait) return bsel;
    if (iact) return '0;
    return en;
  endfunction

  // Behavioural model: advances on each clock edge, clears on async reset.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        m_pres[m] = 0; m_ack[m] = 0; m_bus[m] = 0; m_ptr[m] = 0; m_cnt[m] = 0; m_tout[m] = 0;
        for (int i = 0; i < N; i++) m_blk[m][i] = 0;
      end
      for (int i = 0; i < N; i++) m_tab[i] = '0;
    end else begin
      logic [N-1:0] mk;
      mk = cur_mask();
      for (int m = 0; m < 2; m++) begin
        bit nb [N];
        bit found;
        int start, j;
        for (int i = 0; i < N; i++) nb[i] = sends[i] ? m_blk[m][i] : 1'b0;
        if (m_ack[m]) begin
          nb[m_bus[m]] = 1;
          m_ptr[m] = (m_bus[m] + 1) % N;
          m_ack[m] = 0;
        end else if (m_pres[m]) begin
          if (take) begin
            m_pres[m] = 0;
            m_ack[m]  = 1;
          end else if (!sends[m_bus[m]] || !mk[m_bus[m]]) begin
            m_pres[m] = 0;
          end else if (TMO_ON) begin
            m_cnt[m]++;
            if (m_cnt[m] == TMO) begin
              m_pres[m] = 0;
              nb[m_bus[m]] = 1;
              m_tout[m] = 1;
            end
          end
        end else begin
          found = 0;
          start = (m == 1) ? m_ptr[m] : 0;
          for (int k = 0; k < N; k++) begin
            j = (start + k) % N;
            if (!found && sends[j] && !m_blk[m][j] && mk[j]) begin
              found = 1; m_pres[m] = 1; m_bus[m] = j; m_cnt[m] = 0;
            end
          end
        end
        for (int i = 0; i < N; i++) m_blk[m][i] = nb[i];
      end
      if (cfg_we && cfg_bus < N) m_tab[cfg_bus] = cfg_addr;
    end
  end

  // Compare process: every falling edge, both instances against the model.
  initial forever begin
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_valid", iname[m]), 64'(o_valid[m]), 64'(m_pres[m]));
      chk($sformatf("%s_bus", iname[m]), 64'(o_bus[m]), 64'(m_bus[m]));
      chk($sformatf("%s_acks", iname[m]), 64'(o_acks[m]),
          m_ack[m] ? 64'(1) << m_bus[m] : 64'(0));
      chk($sformatf("%s_timeout", iname[m]), 64'(o_tout[m]), 64'(TMO_ON && m_tout[m]));
      if (m_pres[m]) begin
        chk($sformatf("%s_addr", iname[m]), 64'(o_addr[m]), 64'(m_tab[m_bus[m]]));
        chk($sformatf("%s_data", iname[m]), 64'(o_data[m]), 64'(datas[m_bus[m]*W +: W]));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sends = '0; en = '0; bsel = '0; cwait = 0; iact = 0; take = 0; cfg_we = 0;
    cfg_bus = '0; cfg_addr = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    #2;
    reset = 1;
  endtask

  task automatic wait_valid(input int m, input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      if (o_valid[m]) begin
        ok = 1;
        break;
      end
      cyc();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    bit ok;
    int b;
    for (int i = 0; i < N; i++) datas[i*W +: W] = 32'hD000_0000 + 32'(i);

    // Reset state.
    #3;
    for (int m = 0; m < 2; m++) begin
      chk("rst_valid", 64'(o_valid[m]), 0);
      chk("rst_bus", 64'(o_bus[m]), 0);
      chk("rst_addr", 64'(o_addr[m]), 0);
      chk("rst_data", 64'(o_data[m]), 0);
      chk("rst_acks", 64'(o_acks[m]), 0);
      chk("rst_timeout", 64'(o_tout[m]), 0);
    end
    @(negedge clk); #1;
    reset = 1;

    // Fixed priority, sends 1010 -> bus 1, ack 0010.
    en = 4'b1111; sends = 4'b1010;
    chk("t1_pre_valid", 64'(o_valid[0]), 0);
    cyc();
    chk("t1_valid", 64'(o_valid[0]), 1);
    chk("t1_bus", 64'(o_bus[0]), 1);
    chk("t1_data", 64'(o_data[0]), 64'h D000_0001);
    take = 1;
    cyc();
    take = 0; sends = '0;
    chk("t1_ack", 64'(o_acks[0]), 64'b0010);
    chk("t1_valid_in_ack", 64'(o_valid[0]), 0);
    cyc();
    chk("t1_ack_one_cycle", 64'(o_acks[0]), 0);

    // Round-robin grant order with all sends held.
    do_reset();
    en = 4'b1111; sends = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_valid(1, 10, ok);
      chk("rr_wait_valid", 64'(ok), 1);
      chk($sformatf("rr_order_%0d", g), 64'(o_bus[1]), 64'(exp_order[g]));
      b = int'(o_bus[1]) % N;
      take = 1;
      cyc();
      take = 0; sends[b] = 0;
      cyc();
      cyc();
      sends[b] = 1;
    end

    // Withdrawal of a pending send.
    do_reset();
    en = 4'b1111; sends = 4'b0100;
    cyc();
    chk("wd_valid", 64'(o_valid[0]), 1);
    chk("wd_bus", 64'(o_bus[0]), 2);
    sends = '0;
    cyc();
    chk("wd_valid_drop", 64'(o_valid[0]), 0);
    chk("wd_acks", 64'(o_acks[0]), 0);
    cyc();
    chk("wd_acks_later", 64'(o_acks[0]), 0);

    // WAIT mask selection overrides enables and interrupt_active.
    do_reset();
    cwait = 1; bsel = 4'b0100; en = 4'b0000; iact = 1; sends = 4'b0101;
    cyc();
    for (int m = 0; m < 2; m++) begin
      chk("wait_valid", 64'(o_valid[m]), 1);
      chk("wait_bus", 64'(o_bus[m]), 2);
    end
    clear_inputs();
    cyc();

    // Handler table write, out-of-range write ignored, live update, and ack blocking.
    do_reset();
    cfg_we = 1; cfg_bus = 3; cfg_addr = 8'h5A;
    cyc();
    cfg_bus = 7; cfg_addr = 8'hFF;
    cyc();
    cfg_we = 0; en = 4'b1111; sends = 4'b1000;
    cyc();
    chk("cfg_addr", 64'(o_addr[0]), 64'h5A);
    cfg_we = 1; cfg_bus = 3; cfg_addr = 8'h33;
    cyc();
    cfg_we = 0;
    chk("cfg_live_addr", 64'(o_addr[0]), 64'h33);
    take = 1;
    cyc();
    take = 0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("blk_no_regrant", 64'(o_valid[0]), 0);
    end
    sends = '0;
    cyc();
    sends = 4'b1000;
    cyc();
    chk("blk_regrant", 64'(o_valid[0]), 1);

    // Asynchronous reset in the middle of PENDING.
    @(posedge clk); #2;
    reset = 0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("arst_valid", 64'(o_valid[m]), 0);
      chk("arst_bus", 64'(o_bus[m]), 0);
      chk("arst_addr", 64'(o_addr[m]), 0);
      chk("arst_data", 64'(o_data[m]), 0);
      chk("arst_acks", 64'(o_acks[m]), 0);
    end
    @(negedge clk); #1;
    clear_inputs();
    reset = 1;

`ifdef UARC_IRQ_TIMEOUT_EN
    // Watchdog: presented for exactly TMO cycles, then dropped and flagged.
    do_reset();
    en = 4'b1111; sends = 4'b0001;
    cyc();
    for (int c = 0; c < TMO; c++) begin
      chk("tmo_valid", 64'(o_valid[0]), 1);
      cyc();
    end
    chk("tmo_dropped", 64'(o_valid[0]), 0);
    chk("tmo_flag", 64'(o_tout[0]), 1);
    chk("tmo_no_ack", 64'(o_acks[0]), 0);
    cyc();
    chk("tmo_blocked", 64'(o_valid[0]), 0);
    sends = '0;
    cyc();
`endif

    // Randomised traffic checked by the compare process.
    do_reset();
    en = 4'b1111;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        bit acked;
        acked = (m_ack[0] && m_bus[0] == i) || (m_ack[1] && m_bus[1] == i);
        if (acked) begin
          if ($urandom_range(3) != 0) sends[i] = 0;
        end else if (!sends[i]) begin
          sends[i] = ($urandom_range(3) == 0);
        end else if ($urandom_range(31) == 0) begin
          sends[i] = 0;
        end
        if ($urandom_range(1) == 0) datas[i*W +: W] = $urandom;
      end
      if (m_pres[0] || m_pres[1]) take = ($urandom_range(2) != 0);
      else take = ($urandom_range(7) == 0);
      if ($urandom_range(15) == 0) en = N'($urandom);
      if ($urandom_range(15) == 0) bsel = N'($urandom);
      if ($urandom_range(31) == 0) cwait = ~cwait;
      if ($urandom_range(31) == 0) iact = ~iact;
      cfg_we = ($urandom_range(7) == 0);
      cfg_bus = W'($urandom_range(7));
      cfg_addr = PAW'($urandom);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
